// File: rtl/ram_bist_ctrl.sv
// Fill / read-back / compare self-test sequencer for a single-port synchronous RAM.
// RAM-facing outputs and status flags are registered and trail the FSM state by one cycle.
module ram_bist_ctrl #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [1:0]        Mode,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              Busy,
   output logic              Done,
   output logic              Pass,
   output logic [ADDR_W:0]   Err_Count,
   output logic [ADDR_W-1:0] First_Err_Addr,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [DATA_W-1:0] ONE   = DATA_W'(1);
   localparam logic [DATA_W-1:0] MASK3 = DATA_W'(32'hA5A5_5A5A);

   state_t              state;
   state_t              state_n;
   logic [ADDR_W-1:0]   cnt;
   logic [1:0]          mode_q;
   logic                last;
   logic                accept;
   logic                ram_rd;
   logic                rd_valid;
   logic [ADDR_W-1:0]   rd_addr_q;
   logic                miss;

   logic                we_n;
   logic [ADDR_W-1:0]   addr_n;
   logic [DATA_W-1:0]   din_n;
   logic                rd_n;
   logic                busy_n;
   logic                done_n;

   function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                 input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] ax;
      ax = DATA_W'(a);
      case (m)
         2'd0:    pattern = ax;
         2'd1:    pattern = ~ax;
         2'd2:    pattern = ONE << a[4:0];
         default: pattern = MASK3 ^ ax;
      endcase
   endfunction

   // Start is a level request: taken in IDLE, or in DONE once Done has been
   // visible for a cycle. Busy covers the whole run; Done marks final results.
   assign accept    = Start && ((state == S_IDLE) || ((state == S_DONE) && Done));
   assign last      = (cnt == {ADDR_W{1'b1}});
   assign miss      = rd_valid && (ram_dout != pattern(mode_q, rd_addr_q));
   assign Pass      = Done && (Err_Count == '0);
   assign dbg_state = state;

   always_ff @(posedge Clk) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE,
         S_DONE:  if (accept) state_n = S_WRITE;
         S_WRITE: if (last)   state_n = S_READ;
         S_READ:  if (last)   state_n = S_DRAIN;
         S_DRAIN: state_n = S_DONE;
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      we_n   = 1'b0;
      addr_n = '0;
      din_n  = '0;
      rd_n   = 1'b0;
      busy_n = 1'b0;
      done_n = 1'b0;
      case (state)
         S_WRITE: begin
            we_n   = 1'b1;
            addr_n = cnt;
            din_n  = pattern(mode_q, cnt);
            busy_n = 1'b1;
         end
         S_READ: begin
            addr_n = cnt;
            rd_n   = 1'b1;
            busy_n = 1'b1;
         end
         S_DRAIN: busy_n = 1'b1;
         S_DONE:  done_n = ~accept;
         default: ;
      endcase
   end

   // Read data returns one cycle after the address, so the compare works on
   // a delayed copy of the address tagged with a valid flag.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ram_we         <= 1'b0;
         ram_addr       <= '0;
         ram_din        <= '0;
         Busy           <= 1'b0;
         Done           <= 1'b0;
         ram_rd         <= 1'b0;
         rd_valid       <= 1'b0;
         rd_addr_q      <= '0;
         cnt            <= '0;
         mode_q         <= 2'd0;
         Err_Count      <= '0;
         First_Err_Addr <= '0;
      end else begin
         ram_we    <= we_n;
         ram_addr  <= addr_n;
         ram_din   <= din_n;
         Busy      <= busy_n;
         Done      <= done_n;
         ram_rd    <= rd_n;
         rd_valid  <= ram_rd;
         rd_addr_q <= ram_addr;
         if (accept) begin
            mode_q         <= Mode;
            cnt            <= '0;
            Err_Count      <= '0;
            First_Err_Addr <= '0;
         end else begin
            if ((state == S_WRITE) || (state == S_READ)) cnt <= cnt + 1'b1;
            if (miss) begin
               Err_Count <= Err_Count + 1'b1;
               if (Err_Count == '0) First_Err_Addr <= rd_addr_q;
            end
         end
      end
   end

   a_we_only_when_busy: assert property (@(posedge Clk) disable iff (Reset) ram_we |-> Busy);

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural RAM with fault injection, a per-cycle
// timeline model of the run, directed scenarios and randomized runs.
module tb_ram_bist_ctrl;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 64;
   localparam int T_DONE = 2 * DEPTH + 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [1:0]        mode = 2'd0;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;
   logic              busy;
   logic              done;
   logic              pass;
   logic [ADDR_W:0]   err_count;
   logic [ADDR_W-1:0] first_err_addr;
   logic [2:0]        dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   ram_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .Clk            (clk),
      .Reset          (reset),
      .Start          (start),
      .Mode           (mode),
      .ram_we         (ram_we),
      .ram_addr       (ram_addr),
      .ram_din        (ram_din),
      .ram_dout       (ram_dout),
      .Busy           (busy),
      .Done           (done),
      .Pass           (pass),
      .Err_Count      (err_count),
      .First_Err_Addr (first_err_addr),
      .dbg_state      (dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // behavioural RAM with readback fault injection
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] fault_xor [DEPTH];
   logic              force_zero = 1'b0;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= force_zero ? '0 : (mem[ram_addr] ^ fault_xor[ram_addr]);
   end

   function automatic logic [31:0] pat(input int m, input int a);
      logic [31:0] av;
      av = 32'(a);
      case (m)
         0:       pat = av;
         1:       pat = ~av;
         2:       pat = 32'd1 << (a % 32);
         default: pat = 32'hA5A5_5A5A ^ av;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model: t = cycles since the accepting edge, -1 when idle after reset
   int               t = -1;
   int               m_mode = 0;
   bit               bad [DEPTH];
   int               m_err_total = 0;
   logic [DATA_W-1:0] exp_q[$];

   always @(posedge clk) begin
      if (reset) begin
         t = -1;
         m_mode = 0;
         exp_q.delete();
      end else if (start && (t < 0 || t >= T_DONE)) begin
         t = 0;
         m_mode = int'(mode);
         exp_q.delete();
         m_err_total = 0;
         for (int a = 0; a < DEPTH; a++) begin
            logic [31:0] rb;
            exp_q.push_back(pat(m_mode, a));
            rb = force_zero ? 32'h0 : (pat(m_mode, a) ^ fault_xor[a]);
            bad[a] = (rb != pat(m_mode, a));
            if (bad[a]) m_err_total++;
         end
      end else if (t >= 0 && t < 1000000) begin
         t++;
      end
   end

   // per-cycle compare against the model timeline
   logic        e_we, e_busy, e_done, e_pass;
   logic [31:0] e_addr, e_din;
   int          e_errs, e_first;

   always @(negedge clk) begin
      if (cmp_en) begin
         e_we   = (t >= 1 && t <= DEPTH);
         e_busy = (t >= 1 && t <= 2 * DEPTH + 1);
         e_done = (t >= T_DONE);
         e_addr = e_we ? 32'(t - 1) : ((t >= DEPTH + 1 && t <= 2 * DEPTH) ? 32'(t - DEPTH - 1) : 32'h0);
         e_din  = 32'h0;
         if (e_we) begin
            if (exp_q.size() > 0) e_din = exp_q.pop_front();
            else check("din_queue_empty", 64'd1, 64'd0);
         end
         e_errs  = 0;
         e_first = 0;
         for (int a = 0; a < DEPTH; a++) begin
            if (t >= 0 && bad[a] && t >= 2 * DEPTH + 3 + a - DEPTH) begin
               if (e_errs == 0) e_first = a;
               e_errs++;
            end
         end
         e_pass = e_done && (e_errs == 0);
         check("ram_we", ram_we, e_we);
         check("ram_addr", ram_addr, e_addr);
         check("ram_din", ram_din, e_din);
         check("busy", busy, e_busy);
         check("done", done, e_done);
         check("pass", pass, e_pass);
         check("err_count", err_count, e_errs);
         check("first_err_addr", first_err_addr, e_first);
      end
   end

   // driver tasks
   task automatic clear_faults();
      force_zero = 1'b0;
      for (int a = 0; a < DEPTH; a++) fault_xor[a] = 32'h0;
   endtask

   task automatic rand_faults();
      force_zero = ($urandom_range(0, 5) == 0);
      for (int a = 0; a < DEPTH; a++)
         fault_xor[a] = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h1) : 32'h0;
   endtask

   task automatic start_run(input logic [1:0] m);
      @(negedge clk);
      mode  = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int n0, output int n);
      n = n0;
      while (done !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) check("done_timeout", 64'd1, 64'd0);
   endtask

   initial begin
      int  n;
      bit  do_rst, rst_hit;
      int  rst_at;

      clear_faults();
      for (int a = 0; a < DEPTH; a++) bad[a] = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      reset  = 1'b0;

      // idle after reset
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_we", ram_we, 1'b0);
         check("idle_busy", busy, 1'b0);
         check("idle_err", err_count, 0);
      end

      // mode 0, clean RAM, Start pulse with a different Mode during WRITE
      start_run(2'd0);
      repeat (10) @(negedge clk);
      mode  = 2'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(11, n);
      check("m0_latency", n, 130);
      check("m0_pass", pass, 1'b1);
      check("m0_err", err_count, 0);
      check("m0_word37", mem[37], 32'h0000_0025);

      // mode 3, bit 0 flipped on readback of words 5 and 40
      clear_faults();
      fault_xor[5]  = 32'h1;
      fault_xor[40] = 32'h1;
      start_run(2'd3);
      wait_done(0, n);
      check("m3_err", err_count, 2);
      check("m3_first", first_err_addr, 5);
      check("m3_pass", pass, 1'b0);

      // mode 2, every readback zero
      clear_faults();
      force_zero = 1'b1;
      start_run(2'd2);
      wait_done(0, n);
      check("m2_err", err_count, 64);
      check("m2_first", first_err_addr, 0);
      check("m2_pass", pass, 1'b0);

      // reset in READ, then a clean mode 1 run
      start_run(2'd2);
      repeat (69) @(negedge clk);
      check("pre_reset_err", err_count, 3);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("post_reset_busy", busy, 1'b0);
      check("post_reset_err", err_count, 0);
      clear_faults();
      start_run(2'd1);
      wait_done(0, n);
      check("m1_pass", pass, 1'b1);

      // Start held high: back-to-back runs
      @(negedge clk);
      mode  = 2'd1;
      start = 1'b1;
      @(negedge clk);
      wait_done(0, n);
      check("held_first_latency", n, 130);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("held_done_width", done, 1'b0);
         wait_done(1, n);
         check("held_period", n, 131);
      end
      start = 1'b0;
      repeat (3) @(negedge clk);

      // randomized runs with mid-run Mode/Start noise and occasional reset
      for (int r = 0; r < 10; r++) begin
         rand_faults();
         start_run(2'($urandom_range(0, 3)));
         do_rst  = ($urandom_range(0, 4) == 0);
         rst_at  = $urandom_range(1, 125);
         rst_hit = 1'b0;
         for (int c = 1; c <= 125; c++) begin
            @(negedge clk);
            mode  = 2'($urandom);
            reset = do_rst && (c == rst_at);
            if (reset) rst_hit = 1'b1;
            start = !rst_hit && ($urandom_range(0, 15) == 0);
         end
         @(negedge clk);
         start = 1'b0;
         reset = 1'b0;
         if (!do_rst) begin
            wait_done(126, n);
            check("rand_latency", n, 130);
            check("rand_err_total", err_count, m_err_total);
         end
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_bist_ctrl.md
# ram_bist_ctrl

Self-test sequencer for the 64×32 single-port block RAM used in the memory experiment. It drives the RAM's write-enable, address and write-data inputs and consumes its read data, so it sits directly upstream of the RAM (and loops back from `douta`). It fills every word with a selectable pattern, reads every word back, and compares each word against the expected value. It reports pass/fail, an error count and the first failing address for the LED display stage.

## Interface
Parameters:
- `ADDR_W`, default 6: RAM address width; depth is 2^ADDR_W.
- `DATA_W`, default 32: RAM word width.

Ports:
- `Clk`, input, 1: single clock. Everything, including the RAM, is on the rising edge.
- `Reset`, input, 1: synchronous, active-high reset.
- `Start`, input, 1: level sampled each cycle. Honoured only in IDLE or DONE.
- `Mode`, input, 2: pattern select. Latched on an accepted `Start`.
- `ram_we`, output, 1: to RAM `wea`.
- `ram_addr`, output, ADDR_W: to RAM `addra`.
- `ram_din`, output, DATA_W: to RAM `dina`.
- `ram_dout`, input, DATA_W: from RAM `douta`. Valid one cycle after the address is presented.
- `Busy`, output, 1: high in WRITE, READ and DRAIN.
- `Done`, output, 1: high in DONE.
- `Pass`, output, 1: high in DONE when `Err_Count` is 0.
- `Err_Count`, output, ADDR_W+1: number of mismatching words. Range 0..64.
- `First_Err_Addr`, output, ADDR_W: address of the first mismatch. Holds 0 if there is none.

## Operation
- States: IDLE → WRITE → READ → DRAIN → DONE.
- Reset values:
  - State IDLE.
  - `ram_we`, `ram_addr`, `ram_din`, `Busy`, `Done`, `Pass`, `Err_Count` and `First_Err_Addr` all 0.
  - Latched mode = 0.
- IDLE or DONE with `Start`=1 → WRITE.
  - Latch `Mode`.
  - Clear `Err_Count`, `First_Err_Addr`, `Done` and `Pass`.
  - Set the address counter to 0.
- WRITE: `ram_we`=1, `ram_addr`=counter, `ram_din`=P(counter). The counter increments each cycle. After address 2^ADDR_W−1 → READ, with the counter wrapping to 0.
- READ: `ram_we`=0, `ram_addr`=counter. The counter increments each cycle. After the last address → DRAIN.
- DRAIN: one cycle. Compares the final word. Then → DONE.
- DONE: holds the results until the next `Start`.
- Compare: a 1-cycle delayed copy of the read address plus a valid flag is kept. When the valid flag is set:
  - If `ram_dout` ≠ P(delayed addr), `Err_Count` increments.
  - If this is the first error of the run, `First_Err_Addr` = delayed addr.
- Pattern P(a), with `a` zero-extended to DATA_W, selected by the latched mode:
  - 0: `a`.
  - 1: bitwise NOT of `a`.
  - 2: walking one, `1 << a[4:0]`.
  - 3: `32'hA5A5_5A5A` XOR `a`.
- `Err_Count` cannot overflow: it is ADDR_W+1 bits wide and holds at most 2^ADDR_W. No saturation logic is required.
- `Start` during WRITE, READ or DRAIN is ignored. `Mode` changes mid-run are ignored.
- `Reset` asserted in any state → IDLE on the next edge with all outputs at their reset values. RAM contents are not restored.
- `ram_we` is never high outside WRITE.

## Timing
- With `Start` sampled high at edge 0 and depth 64:
  - WRITE occupies cycles 1–64 (address 0..63).
  - READ occupies cycles 65–128.
  - DRAIN is cycle 129.
  - DONE is entered at edge 130.
- Total latency from `Start` to `Done` = 2·2^ADDR_W + 2 cycles.
- Read data for the address presented in cycle k is compared in cycle k+1. The compare for address 63 happens in DRAIN.
- The write of address 63 (cycle 64) is immediately followed by the read of address 0 (cycle 65). No turnaround cycle is inserted.
- `Pass`, `Err_Count` and `First_Err_Addr` are final once `Done`=1. During a run they reflect partial results.
- `Start` held high continuously: after DONE is reached, a new run begins on the following edge. `Done` is high for exactly one cycle.

## Test plan
- Reset and idle: after `Reset`, all outputs are 0 and `ram_we` stays 0 for 20 idle cycles. This is required to pass.
- Mode 0 with a correct RAM model:
  - `Done` rises 130 cycles after `Start`.
  - `Pass`=1, `Err_Count`=0.
  - Word 37 reads back 32'h0000_0025.
- Mode 3 with a stuck bit injected at addresses 5 and 40, flipping bit 0 on readback:
  - `Err_Count`=2, `First_Err_Addr`=5, `Pass`=0.
- Mode 2 with every readback forced to 0:
  - `Err_Count`=64, `First_Err_Addr`=0, `Pass`=0.
- Reset mid-run: assert `Reset` at cycle 70 (in READ).
  - The next cycle is IDLE with `Busy`=0 and `Err_Count`=0.
  - A following `Start` in mode 1 completes with `Pass`=1.
- `Start` pulsed during WRITE has no effect. `Start` held high gives back-to-back runs with `Done` high for 1 cycle every 131 cycles.
